// File: rtl/gs_band_solver.sv
// gs_band_solver: Gauss-Seidel solver for an N-row banded system.
// Row i: 20*x[i] - 13*(x[i-1]+x[i+1]) + 6*(x[i-2]+x[i+2]) - (x[i-3]+x[i+3]) = b[i].
// The loop loads b serially, runs in-place sweeps of ITER iterations (one SUM cycle and
// one DIV cycle per row), then streams x out with its row index.
// Optional feature macro: GS_CONV_EN (early stop once a sweep changes no x by more than TOL).
// Ports:
//   clk        clock, rising edge
//   rst_in     asynchronous, active-high reset
//   in_en      b_in load strobe (accepted only while idle or loading)
//   b_in       right-hand-side element, signed, row order 0..N-1
//   busy       high from the first accepted b word until the last output word
//   out_valid  x_out/x_idx valid
//   x_out      solution element, signed Q(XW-16).16; zero when out_valid is low
//   x_idx      row index of x_out
//   iter_cnt   sweeps completed in the current/last solve
module gs_band_solver #(
    parameter int unsigned N    = 16,
    parameter int unsigned BW   = 16,
    parameter int unsigned XW   = 32,
    parameter int unsigned ITER = 50
`ifdef GS_CONV_EN
    ,
    parameter int unsigned TOL  = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 in_en,
    input  logic [BW-1:0]        b_in,
    output logic                 busy,
    output logic                 out_valid,
    output logic [XW-1:0]        x_out,
    output logic [$clog2(N)-1:0] x_idx,
    output logic [7:0]           iter_cnt
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned AW = XW + 6;   // accumulator: worst case 41*2^(XW-1)
    localparam int unsigned PW = AW + 17;  // accumulator times 17-bit signed constant
    localparam int unsigned DW = XW + 2;   // per-row update magnitude

    localparam logic signed [AW-1:0] C13  = AW'(13);
    localparam logic signed [AW-1:0] C6   = AW'(6);
    // 52429 / 2^20 ~= 1/20
    localparam logic signed [PW-1:0] KDIV = PW'(52429);
    localparam logic signed [PW-1:0] SMAX = PW'({1'b0, {(XW-1){1'b1}}});
    localparam logic signed [PW-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SUM,
        S_DIV,
        S_OUT
    } state_e;

    state_e                 state_q, state_d;
    logic signed [BW-1:0]   b_q [N];
    logic signed [BW-1:0]   b_d [N];
    logic signed [XW-1:0]   x_q [N];
    logic signed [XW-1:0]   x_d [N];
    logic [IW-1:0]          cnt_q, cnt_d;     // load count, then current row
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [7:0]             iter_q, iter_d;
    logic                   busy_q, busy_d;
    logic                   ov_q, ov_d;
    logic [XW-1:0]          xo_q, xo_d;
    logic [IW-1:0]          xi_q, xi_d;

    logic signed [AW-1:0]   xm1, xm2, xm3, xp1, xp2, xp3;
    logic signed [AW-1:0]   acc_sum;
    logic signed [PW-1:0]   prod, shifted;
    logic signed [XW-1:0]   xn;
    logic [7:0]             iter_inc;
    logic                   sweep_stop;

`ifdef GS_CONV_EN
    localparam logic [DW-1:0] TOL_W = DW'(TOL);
    logic [DW-1:0]          dmax_q, dmax_d;
    logic signed [DW-1:0]   diff;
    logic [DW-1:0]          absd, dmax_new;
`endif

    // Neighbour fetch; rows outside 0..N-1 read as zero.
    always_comb begin : nbr_fetch
        xm1 = '0;
        xm2 = '0;
        xm3 = '0;
        xp1 = '0;
        xp2 = '0;
        xp3 = '0;
        if (32'(cnt_q) >= 1)     xm1 = AW'(x_q[cnt_q - IW'(1)]);
        if (32'(cnt_q) >= 2)     xm2 = AW'(x_q[cnt_q - IW'(2)]);
        if (32'(cnt_q) >= 3)     xm3 = AW'(x_q[cnt_q - IW'(3)]);
        if (32'(cnt_q) + 1 < N)  xp1 = AW'(x_q[cnt_q + IW'(1)]);
        if (32'(cnt_q) + 2 < N)  xp2 = AW'(x_q[cnt_q + IW'(2)]);
        if (32'(cnt_q) + 3 < N)  xp3 = AW'(x_q[cnt_q + IW'(3)]);
        acc_sum = (AW'(b_q[cnt_q]) <<< 16) + C13 * (xm1 + xp1)
                - C6 * (xm2 + xp2) + (xm3 + xp3);
    end

    // Divide by 20 via reciprocal multiply, floor, saturate; sweep-end decision.
    always_comb begin : div_dp
        prod     = PW'(acc_q) * KDIV;
        shifted  = prod >>> 20;
        if (shifted > SMAX)      xn = SMAX[XW-1:0];
        else if (shifted < SMIN) xn = SMIN[XW-1:0];
        else                     xn = shifted[XW-1:0];
        iter_inc = iter_q + 8'd1;
`ifdef GS_CONV_EN
        diff       = DW'(xn) - DW'(x_q[cnt_q]);
        absd       = diff[DW-1] ? -diff : diff;
        dmax_new   = (absd > dmax_q) ? absd : dmax_q;
        sweep_stop = (iter_inc == 8'(ITER)) || (dmax_new <= TOL_W);
`else
        sweep_stop = (iter_inc == 8'(ITER));
`endif
    end

    // Next-state and register-input logic.
    always_comb begin : fsm_next
        state_d = state_q;
        b_d     = b_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        ov_d    = 1'b0;
        xo_d    = '0;
        xi_d    = '0;
`ifdef GS_CONV_EN
        dmax_d  = dmax_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_en) begin
                    b_d[0] = b_in;
                    cnt_d  = IW'(1);
                    for (int k = 0; k < N; k++) x_d[k] = '0;
                    iter_d = '0;
`ifdef GS_CONV_EN
                    dmax_d = '0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_en) begin
                    b_d[cnt_q] = b_in;
                    if (32'(cnt_q) == N - 1) begin
                        cnt_d   = '0;
                        state_d = S_SUM;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            S_SUM: begin
                acc_d   = acc_sum;
                state_d = S_DIV;
            end
            S_DIV: begin
                x_d[cnt_q] = xn;
                if (32'(cnt_q) < N - 1) begin
                    cnt_d   = cnt_q + IW'(1);
`ifdef GS_CONV_EN
                    dmax_d  = dmax_new;
`endif
                    state_d = S_SUM;
                end else begin
                    cnt_d  = '0;
                    iter_d = iter_inc;
`ifdef GS_CONV_EN
                    dmax_d = '0;
`endif
                    if (sweep_stop) begin
                        // Row 0 is already final; present it in the first OUT cycle.
                        ov_d    = 1'b1;
                        xo_d    = x_q[0];
                        state_d = S_OUT;
                    end else begin
                        state_d = S_SUM;
                    end
                end
            end
            S_OUT: begin
                if (32'(xi_q) < N - 1) begin
                    ov_d = 1'b1;
                    xi_d = xi_q + IW'(1);
                    xo_d = x_q[xi_q + IW'(1)];
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N; k++) begin
                b_q[k] <= '0;
                x_q[k] <= '0;
            end
            cnt_q   <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            ov_q    <= 1'b0;
            xo_q    <= '0;
            xi_q    <= '0;
`ifdef GS_CONV_EN
            dmax_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            ov_q    <= ov_d;
            xo_q    <= xo_d;
            xi_q    <= xi_d;
`ifdef GS_CONV_EN
            dmax_q  <= dmax_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign out_valid = ov_q;
    assign x_out     = xo_q;
    assign x_idx     = xi_q;
    assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_gs_band_solver.sv
// Bench for gs_band_solver: two instances (16 rows/50 sweeps, 8 rows/1 sweep).
module tb_gs_band_solver;

    localparam int N0  = 16;
    localparam int N1  = 8;
    localparam int IT0 = 50;
    localparam int IT1 = 1;
    localparam int BW  = 16;
    localparam int XW  = 32;
`ifdef GS_CONV_EN
    localparam int RST_SWEEP = 1;
`else
    localparam int RST_SWEEP = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_in;
    logic          in_en0, in_en1;
    logic [BW-1:0] b_in0, b_in1;
    logic          busy0, busy1, out_valid0, out_valid1;
    logic [XW-1:0] x_out0, x_out1;
    logic [3:0]    x_idx0;
    logic [2:0]    x_idx1;
    logic [7:0]    iter_cnt0, iter_cnt1;

    always #5 clk = ~clk;

    gs_band_solver #(.N(N0), .BW(BW), .XW(XW), .ITER(IT0)) dut0 (
        .clk(clk), .rst_in(rst_in), .in_en(in_en0), .b_in(b_in0), .busy(busy0),
        .out_valid(out_valid0), .x_out(x_out0), .x_idx(x_idx0), .iter_cnt(iter_cnt0));

    gs_band_solver #(.N(N1), .BW(BW), .XW(XW), .ITER(IT1)) dut1 (
        .clk(clk), .rst_in(rst_in), .in_en(in_en1), .b_in(b_in1), .busy(busy1),
        .out_valid(out_valid1), .x_out(x_out1), .x_idx(x_idx1), .iter_cnt(iter_cnt1));

    typedef struct {
        int idx;
        int x;
        int it;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   qb0[$];
    int   qb1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;
    bit   rst_chk_req = 1'b0;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;
    int   bcnt0 = 0;
    int   bcnt1 = 0;

    int bvec [64];
    int mx [64];
    int mit;
    int b3 [16] = '{1000, -2000, 32767, -32768, 5, 0, -1, 12345,
                    -23456, 777, 30000, -30000, 42, -7, 16000, -16000};

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents output.
    always @(negedge clk) begin
        if (rst_chk_req) begin
            chk("rst busy0", longint'(busy0), 0);
            chk("rst out_valid0", longint'(out_valid0), 0);
            chk("rst x_out0", longint'(x_out0), 0);
            chk("rst x_idx0", longint'(x_idx0), 0);
            chk("rst iter_cnt0", longint'(iter_cnt0), 0);
            chk("rst busy1", longint'(busy1), 0);
            chk("rst out_valid1", longint'(out_valid1), 0);
            bcnt0 = 0;
            bcnt1 = 0;
        end else begin
            if (out_valid0) begin
                if (q0.size() == 0) chk("unexpected beat dut0", 1, 0);
                else begin
                    e0 = q0.pop_front();
                    chk("x_idx0", longint'(x_idx0), longint'(e0.idx));
                    chk("x_out0", longint'($signed(x_out0)), longint'(e0.x));
                    chk("iter_cnt0", longint'(iter_cnt0), longint'(e0.it));
                end
            end else begin
                chk("x_out0 idle zero", longint'(x_out0), 0);
            end
            if (out_valid1) begin
                if (q1.size() == 0) chk("unexpected beat dut1", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    chk("x_idx1", longint'(x_idx1), longint'(e1.idx));
                    chk("x_out1", longint'($signed(x_out1)), longint'(e1.x));
                    chk("iter_cnt1", longint'(iter_cnt1), longint'(e1.it));
                end
            end else begin
                chk("x_out1 idle zero", longint'(x_out1), 0);
            end
            if (busy0) bcnt0++;
            else if (bcnt0 != 0) begin
                if (qb0.size() == 0) chk("unexpected busy dut0", 1, 0);
                else chk("busy0 length", longint'(bcnt0), longint'(qb0.pop_front()));
                bcnt0 = 0;
            end
            if (busy1) bcnt1++;
            else if (bcnt1 != 0) begin
                if (qb1.size() == 0) chk("unexpected busy dut1", 1, 0);
                else chk("busy1 length", longint'(bcnt1), longint'(qb1.pop_front()));
                bcnt1 = 0;
            end
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            chk("dut0 beats left", longint'(q0.size()), 0);
            chk("dut1 beats left", longint'(q1.size()), 0);
            chk("dut0 busy ends left", longint'(qb0.size()), 0);
            chk("dut1 busy ends left", longint'(qb1.size()), 0);
        end
    end

    function automatic longint xv(input int n, input int k);
        if (k < 0 || k >= n) return 0;
        return longint'(mx[k]);
    endfunction

    // Reference Gauss-Seidel over bvec, results in mx/mit.
    task automatic run_model(input int n, input int iters);
        longint acc, p;
`ifdef GS_CONV_EN
        longint d, dmax;
`endif
        for (int k = 0; k < 64; k++) mx[k] = 0;
        mit = 0;
        for (int s = 0; s < iters; s++) begin
`ifdef GS_CONV_EN
            dmax = 0;
`endif
            for (int i = 0; i < n; i++) begin
                acc = longint'(bvec[i]) * 65536 + 13 * (xv(n, i - 1) + xv(n, i + 1))
                    - 6 * (xv(n, i - 2) + xv(n, i + 2)) + xv(n, i - 3) + xv(n, i + 3);
                p = (acc * 52429) >>> 20;
                if (p > 64'sd2147483647) p = 64'sd2147483647;
                if (p < -64'sd2147483648) p = -64'sd2147483648;
`ifdef GS_CONV_EN
                d = p - longint'(mx[i]);
                if (d < 0) d = -d;
                if (d > dmax) dmax = d;
`endif
                mx[i] = int'(p);
            end
            mit++;
`ifdef GS_CONV_EN
            if (dmax <= 4) break;
`endif
        end
    endtask

    task automatic push_exp(input int which, input int n, input int iters, input int gap);
        exp_t e;
        run_model(n, iters);
        for (int k = 0; k < n; k++) begin
            e.idx = k;
            e.x   = mx[k];
            e.it  = mit;
            if (which == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (which == 0) qb0.push_back((n - 1) * (1 + gap) + 2 * n * mit + n);
        else qb1.push_back((n - 1) * (1 + gap) + 2 * n * mit + n);
    endtask

    task automatic load(input int which, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (which == 0) begin in_en0 = 1'b1; b_in0 = BW'(bvec[i]); end
            else begin in_en1 = 1'b1; b_in1 = BW'(bvec[i]); end
            @(posedge clk); #1;
            in_en0 = 1'b0;
            in_en1 = 1'b0;
            if (i != n - 1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle(input int which, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            if ((which == 0 && !busy0) || (which == 1 && !busy1)) return;
        end
        $display("FAIL wait_idle dut%0d: busy still 1 after %0d cycles, required 0", which, limit);
        $fatal(1, "timeout");
    endtask

    task automatic wait_cond0(input int mode, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            if (mode == 0 && out_valid0) return;
            if (mode == 1 && out_valid0 && x_idx0 == 4'd15) return;
            if (mode == 2 && iter_cnt0 == 8'(RST_SWEEP)) return;
        end
        $display("FAIL wait_cond0 mode %0d: condition not reached in %0d cycles", mode, limit);
        $fatal(1, "timeout");
    endtask

    initial begin
        exp_t e;
        rst_in = 1'b1;
        rst_chk_req = 1'b1;
        in_en0 = 1'b0;
        in_en1 = 1'b0;
        b_in0 = '0;
        b_in1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        rst_chk_req = 1'b0;
        @(posedge clk); #1;

        // All-zero right-hand side.
        for (int k = 0; k < 64; k++) bvec[k] = 0;
        push_exp(0, N0, IT0, 0);
        load(0, N0, 0);
        wait_idle(0, 3000);

        // Mixed-sign vector including the b extremes.
        for (int k = 0; k < N0; k++) bvec[k] = b3[k];
        push_exp(0, N0, IT0, 0);
        load(0, N0, 0);
        wait_idle(0, 3000);

        // Same vector, 3-cycle load gaps, stray strobes while solving and streaming.
        push_exp(0, N0, IT0, 3);
        load(0, N0, 3);
        repeat (5) begin @(posedge clk); #1; end
        in_en0 = 1'b1; b_in0 = 16'h7FFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_en0 = 1'b0;
        repeat (37) begin @(posedge clk); #1; end
        in_en0 = 1'b1;
        @(posedge clk); #1;
        in_en0 = 1'b0;
        wait_cond0(0, 3000);
        in_en0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_en0 = 1'b0;
        wait_cond0(1, 100);
        in_en0 = 1'b1;
        @(posedge clk); #1;
        in_en0 = 1'b0;
        wait_idle(0, 100);

        // Reset part-way through a row, then a clean reload.
        load(0, N0, 0);
        wait_cond0(2, 3000);
        repeat (7) begin @(posedge clk); #1; end
        rst_in = 1'b1;
        rst_chk_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        rst_chk_req = 1'b0;
        @(posedge clk); #1;
        push_exp(0, N0, IT0, 0);
        load(0, N0, 0);
        wait_idle(0, 3000);

        // Large constant b drives x towards the saturation limits; constant 100.
        for (int k = 0; k < N0; k++) bvec[k] = 32767;
        push_exp(0, N0, IT0, 0);
        load(0, N0, 0);
        wait_idle(0, 3000);
        for (int k = 0; k < N0; k++) bvec[k] = 100;
        push_exp(0, N0, IT0, 0);
        load(0, N0, 0);
        wait_idle(0, 3000);

        // Single sweep with b[0]=20: rows 0..3 worked by hand, busy 7+16+8 cycles.
        for (int k = 0; k < 64; k++) bvec[k] = 0;
        bvec[0] = 20;
        run_model(N1, IT1);
        for (int k = 0; k < N1; k++) begin
            e.idx = k;
            e.it  = 1;
            case (k)
                0: e.x = 65536;
                1: e.x = 42598;
                2: e.x = 8027;
                3: e.x = -4286;
                default: e.x = mx[k];
            endcase
            q1.push_back(e);
        end
        qb1.push_back(31);
        load(1, N1, 0);
        wait_idle(1, 200);

        // Eight-row solve of the mixed vector.
        for (int k = 0; k < N1; k++) bvec[k] = b3[k];
        push_exp(1, N1, IT1, 2);
        load(1, N1, 2);
        wait_idle(1, 200);

        repeat (4) begin @(posedge clk); #1; end
        end_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
